cordic_phase_sequencer: RTL and testbench

Generates the phase stream that drives the CORDIC sine source and buffers the returned samples for the SAR converter. Each cycle it steps a wrapping fixed-point phase accumulator at a programmable sample rate and issues one phase word per sample tick. It uses credit-based flow control so that the non-blocking CORDIC core (no tready) can never overrun the result buffer. Results are handed to the SAR front end through a valid/ready interface.

---
 rtl/sar_cordic_pkg.sv | 33 +++
 rtl/sample_fifo.sv | 75 +++++++
 rtl/cordic_phase_sequencer.sv | 162 ++++++++++++++++
 tb/tb_cordic_phase_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_cordic_pkg.sv
// Shared constants, state encoding and the phase-wrap helper for the CORDIC
// phase sequencer and its result buffer.
package sar_cordic_pkg;

  localparam int PHASE_W   = 16;
  localparam int PI_FX     = 25736;
  localparam int TWO_PI_FX = 51472;

  localparam logic signed [PHASE_W:0] PI_S     = (PHASE_W+1)'(PI_FX);
  localparam logic signed [PHASE_W:0] TWO_PI_S = (PHASE_W+1)'(TWO_PI_FX);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } seq_state_e;

  // Advance a fix16_13 phase by a clamped step and wrap it back into [-pi, pi].
  function automatic logic signed [PHASE_W-1:0] phase_step(
    input logic signed [PHASE_W-1:0] acc,
    input logic        [PHASE_W-1:0] inc
  );
    logic        [PHASE_W-1:0] inc_c;
    logic signed [PHASE_W:0]   sum;
    inc_c = (inc > PHASE_W'(PI_FX)) ? PHASE_W'(PI_FX) : inc;
    sum   = {acc[PHASE_W-1], acc} + $signed({1'b0, inc_c});
    if (sum > PI_S) begin
      sum = sum - TWO_PI_S;
    end
    return sum[PHASE_W-1:0];
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through result buffer: the head word is visible straight
// from storage, and a push into a full buffer succeeds only alongside a pop.
module sample_fifo
  import sar_cordic_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = PHASE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic                       not_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, do_pop, do_push;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign not_empty = (count_q != '0);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && not_empty;
    do_push  = push && (!full || do_pop);
    drop     = push && full && !do_pop;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset because the head word is an output that must read 0 out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cordic_phase_sequencer.sv
// Issues a wrapping phase stream to the CORDIC core at a programmable rate and
// buffers the returned samples, using credits so the core can never overrun.
module cordic_phase_sequencer
  import sar_cordic_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] phase_inc,
  input  logic [15:0] rate_div,
  input  logic        clear_err,
  output logic [15:0] phase_tdata,
  output logic        phase_tvalid,
  input  logic [15:0] dout_tdata,
  input  logic        dout_tvalid,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] missed_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH);

  seq_state_e                state_q, state_d;
  logic signed [PHASE_W-1:0] acc_q, acc_d;
  logic [15:0]               div_q, div_d;
  logic                      tick_q, tick_d;
  logic [CW:0]               out_q, out_d;
  logic [PHASE_W-1:0]        phase_q, phase_d;
  logic                      ptv_q, ptv_d;
  logic                      overrun_q, overrun_d;
  logic [15:0]               missed_q, missed_d;

  logic [CW:0] fifo_count;
  logic        fifo_drop;
  logic        credit, issue, miss, ret;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PHASE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (dout_tvalid),
    .push_data (dout_tdata),
    .pop       (sample_ready),
    .head_data (sample_data),
    .not_empty (sample_valid),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  // Credits count both buffered and still-in-flight results.
  assign credit = ((CW+2)'(out_q) + (CW+2)'(fifo_count)) < (CW+2)'(FIFO_DEPTH);
  assign issue  = (state_q == RUN) && tick_q && credit;
  assign miss   = (state_q == RUN) && tick_q && !credit;
  assign ret    = dout_tvalid && (out_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN:   if (out_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    acc_d     = acc_q;
    div_d     = div_q;
    tick_d    = 1'b0;
    out_d     = out_q;
    phase_d   = phase_q;
    ptv_d     = 1'b0;
    overrun_d = overrun_q;
    missed_d  = missed_q;

    if (state_q == IDLE && enable) begin
      acc_d = '0;
      div_d = '0;
    end

    if (state_q == RUN) begin
      if (div_q == '0) begin
        tick_d = 1'b1;
        div_d  = rate_div;
      end else begin
        div_d = div_q - 16'd1;
      end
    end

    if (issue) begin
      phase_d = acc_q;
      ptv_d   = 1'b1;
      acc_d   = phase_step(acc_q, phase_inc);
    end

    if (issue && !ret) begin
      out_d = out_q + (CW+1)'(1);
    end else if (ret && !issue) begin
      out_d = out_q - (CW+1)'(1);
    end

    // The error clear wins over a same-cycle miss or overrun.
    if (clear_err) begin
      missed_d  = '0;
      overrun_d = 1'b0;
    end else begin
      if (miss && missed_q != 16'hFFFF) begin
        missed_d = missed_q + 16'd1;
      end
      if (fifo_drop) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      div_q     <= '0;
      tick_q    <= 1'b0;
      out_q     <= '0;
      phase_q   <= '0;
      ptv_q     <= 1'b0;
      overrun_q <= 1'b0;
      missed_q  <= '0;
    end else begin
      acc_q     <= acc_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      out_q     <= out_d;
      phase_q   <= phase_d;
      ptv_q     <= ptv_d;
      overrun_q <= overrun_d;
      missed_q  <= missed_d;
    end
  end

  assign phase_tdata  = phase_q;
  assign phase_tvalid = ptv_q;
  assign overrun      = overrun_q;
  assign missed_cnt   = missed_q;

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Bench for cordic_phase_sequencer: a 3-cycle CORDIC model feeds results back,
// a negedge monitor logs phases and consumed samples against the model queue.
module tb_cordic_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] phase_inc = '0;
  logic [15:0] rate_div = '0;
  logic        clear_err = 1'b0;
  logic [15:0] phase_tdata;
  logic        phase_tvalid;
  logic [15:0] dout_tdata;
  logic        dout_tvalid;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        busy;
  logic        overrun;
  logic [15:0] missed_cnt;

  logic        model_v = 1'b0;
  logic [15:0] model_d = '0;
  logic        inject_v = 1'b0;
  logic [15:0] inject_d = '0;

  logic        pv0 = 1'b0, pv1 = 1'b0;
  logic [15:0] pd0 = '0, pd1 = '0;

  logic [15:0] ph_log[$];
  int          ph_cyc[$];
  logic [15:0] got_samp[$];
  logic [15:0] exp_samp[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ph_base = 0;
  int got_idx = 0;
  int exp_idx = 0;

  assign dout_tvalid = model_v | inject_v;
  assign dout_tdata  = inject_v ? inject_d : model_d;

  cordic_phase_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .phase_inc    (phase_inc),
    .rate_div     (rate_div),
    .clear_err    (clear_err),
    .phase_tdata  (phase_tdata),
    .phase_tvalid (phase_tvalid),
    .dout_tdata   (dout_tdata),
    .dout_tvalid  (dout_tvalid),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun),
    .missed_cnt   (missed_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor plus CORDIC model: result = phase ^ 16'hA5C3, three cycles after the pulse.
  always @(negedge clk) begin
    if (phase_tvalid === 1'b1) begin
      ph_log.push_back(phase_tdata);
      ph_cyc.push_back(cyc);
    end
    if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
      got_samp.push_back(sample_data);
    end
    model_v = pv1;
    model_d = pd1 ^ 16'hA5C3;
    if (pv1) exp_samp.push_back(pd1 ^ 16'hA5C3);
    pv1 = pv0;
    pd1 = pd0;
    pv0 = (phase_tvalid === 1'b1);
    pd0 = phase_tdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    enable = 1'b0;
    while (busy !== 1'b0 && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy=%b required 0 within 200 cycles", busy);
    end
    tick(8);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    checks += 7;
    if (phase_tdata !== 16'h0)  begin errors++; $display("FAIL rst_phase_tdata got %h want 0000", phase_tdata); end
    if (phase_tvalid !== 1'b0)  begin errors++; $display("FAIL rst_phase_tvalid got %b want 0", phase_tvalid); end
    if (sample_valid !== 1'b0)  begin errors++; $display("FAIL rst_sample_valid got %b want 0", sample_valid); end
    if (sample_data !== 16'h0)  begin errors++; $display("FAIL rst_sample_data got %h want 0000", sample_data); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (overrun !== 1'b0)       begin errors++; $display("FAIL rst_overrun got %b want 0", overrun); end
    if (missed_cnt !== 16'h0)   begin errors++; $display("FAIL rst_missed got %h want 0000", missed_cnt); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_basic_run();
    logic [15:0] exp_ph [6];
    int n;
    exp_ph = '{16'h0000, 16'h2000, 16'h4000, 16'h6000, 16'hB6F0, 16'hD6F0};
    phase_inc = 16'd8192;
    rate_div = 16'd0;
    sample_ready = 1'b1;
    ph_base = ph_log.size();
    enable = 1'b1;
    tick(1);
    checks += 2;
    if (busy !== 1'b1)         begin errors++; $display("FAIL basic_busy_edge_n got %b want 1", busy); end
    if (phase_tvalid !== 1'b0) begin errors++; $display("FAIL basic_tvalid_edge_n got %b want 0", phase_tvalid); end
    tick(1);
    checks++;
    if (phase_tvalid !== 1'b0) begin errors++; $display("FAIL basic_tvalid_edge_n1 got %b want 0", phase_tvalid); end
    tick(1);
    checks += 2;
    if (phase_tvalid !== 1'b1) begin errors++; $display("FAIL basic_tvalid_edge_n2 got %b want 1", phase_tvalid); end
    if (phase_tdata !== 16'h0) begin errors++; $display("FAIL basic_first_phase got %h want 0000", phase_tdata); end
    tick(10);
    wait_idle();
    n = ph_log.size() - ph_base;
    checks++;
    if (n < 6) begin
      errors++;
      $display("FAIL basic_phase_count got %0d want at least 6", n);
    end
    for (int i = 0; i < 6 && i < n; i++) begin
      checks++;
      if (ph_log[ph_base+i] !== exp_ph[i]) begin
        errors++;
        $display("FAIL basic_phase[%0d] got %h want %h", i, ph_log[ph_base+i], exp_ph[i]);
      end
    end
    checks++;
    if (got_samp.size() - got_idx != n) begin
      errors++;
      $display("FAIL basic_sample_count got %0d want %0d", got_samp.size() - got_idx, n);
    end
    for (int i = 0; got_idx + i < got_samp.size() && exp_idx + i < exp_samp.size(); i++) begin
      checks++;
      if (got_samp[got_idx+i] !== exp_samp[exp_idx+i]) begin
        errors++;
        $display("FAIL basic_sample[%0d] got %h want %h", i, got_samp[got_idx+i], exp_samp[exp_idx+i]);
      end
    end
    got_idx = got_samp.size();
    exp_idx = exp_samp.size();
  endtask

  task automatic test_rate_divider();
    int n;
    pulse_clear();
    rate_div = 16'd3;
    phase_inc = 16'd500;
    sample_ready = 1'b1;
    ph_base = ph_log.size();
    enable = 1'b1;
    tick(40);
    wait_idle();
    n = ph_log.size() - ph_base;
    checks++;
    if (n < 8) begin
      errors++;
      $display("FAIL rate_pulse_count got %0d want at least 8", n);
    end
    for (int i = 1; i < 8 && i < n; i++) begin
      checks++;
      if (ph_cyc[ph_base+i] - ph_cyc[ph_base+i-1] != 4) begin
        errors++;
        $display("FAIL rate_spacing[%0d] got %0d want 4", i, ph_cyc[ph_base+i] - ph_cyc[ph_base+i-1]);
      end
    end
    checks++;
    if (missed_cnt !== 16'h0) begin errors++; $display("FAIL rate_missed got %0d want 0", missed_cnt); end
    got_idx = got_samp.size();
    exp_idx = exp_samp.size();
    rate_div = 16'd0;
  endtask

  task automatic test_backpressure();
    int n;
    pulse_clear();
    sample_ready = 1'b0;
    rate_div = 16'd0;
    phase_inc = 16'd1000;
    ph_base = ph_log.size();
    enable = 1'b1;
    tick(1);
    tick(12);
    checks += 2;
    if (missed_cnt !== 16'd7) begin errors++; $display("FAIL bp_missed_n12 got %0d want 7", missed_cnt); end
    if (ph_log.size() - ph_base != 4) begin
      errors++;
      $display("FAIL bp_issue_count got %0d want 4", ph_log.size() - ph_base);
    end
    tick(1);
    checks++;
    if (missed_cnt !== 16'd8) begin errors++; $display("FAIL bp_missed_n13 got %0d want 8", missed_cnt); end
    sample_ready = 1'b1;
    tick(12);
    wait_idle();
    n = ph_log.size() - ph_base;
    checks++;
    if (n < 8) begin
      errors++;
      $display("FAIL bp_resume_count got %0d want at least 8", n);
    end
    for (int i = 0; i < 8 && i < n; i++) begin
      checks++;
      if (ph_log[ph_base+i] !== 16'(i * 1000)) begin
        errors++;
        $display("FAIL bp_phase[%0d] got %0d want %0d", i, ph_log[ph_base+i], i * 1000);
      end
    end
    checks++;
    if (got_samp.size() - got_idx != n) begin
      errors++;
      $display("FAIL bp_sample_count got %0d want %0d", got_samp.size() - got_idx, n);
    end
    for (int i = 0; got_idx + i < got_samp.size() && exp_idx + i < exp_samp.size(); i++) begin
      checks++;
      if (got_samp[got_idx+i] !== exp_samp[exp_idx+i]) begin
        errors++;
        $display("FAIL bp_sample[%0d] got %h want %h", i, got_samp[got_idx+i], exp_samp[exp_idx+i]);
      end
    end
    got_idx = got_samp.size();
    exp_idx = exp_samp.size();
  endtask

  task automatic test_stop_mid_run();
    phase_inc = 16'd8192;
    rate_div = 16'd0;
    sample_ready = 1'b1;
    ph_base = ph_log.size();
    enable = 1'b1;
    tick(3);
    enable = 1'b0;
    tick(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy_drain got %b want 1", busy); end
    tick(1);
    checks++;
    if (ph_log.size() - ph_base != 2) begin
      errors++;
      $display("FAIL stop_pulse_count got %0d want 2", ph_log.size() - ph_base);
    end
    tick(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy_before_last got %b want 1", busy); end
    tick(1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy_after_last got %b want 0", busy); end
    tick(8);
    checks += 2;
    if (ph_log.size() - ph_base != 2) begin
      errors++;
      $display("FAIL stop_no_new_pulses got %0d want 2", ph_log.size() - ph_base);
    end
    if (got_samp.size() - got_idx != 2) begin
      errors++;
      $display("FAIL stop_sample_count got %0d want 2", got_samp.size() - got_idx);
    end
    got_idx = got_samp.size();
    exp_idx = exp_samp.size();
  endtask

  task automatic test_overrun();
    logic [15:0] head;
    pulse_clear();
    sample_ready = 1'b0;
    rate_div = 16'd0;
    phase_inc = 16'd3000;
    enable = 1'b1;
    tick(10);
    wait_idle();
    head = (exp_idx < exp_samp.size()) ? exp_samp[exp_idx] : 16'hxxxx;
    checks += 3;
    if (sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_fifo_full_valid got %b want 1", sample_valid); end
    if (sample_data !== head)  begin errors++; $display("FAIL ovr_head_before got %h want %h", sample_data, head); end
    if (missed_cnt === 16'h0)  begin errors++; $display("FAIL ovr_missed_nonzero got %0d want >0", missed_cnt); end
    inject_v = 1'b1;
    inject_d = 16'hDEAD;
    tick(1);
    inject_v = 1'b0;
    checks += 2;
    if (overrun !== 1'b1)     begin errors++; $display("FAIL ovr_sticky_set got %b want 1", overrun); end
    if (sample_data !== head) begin errors++; $display("FAIL ovr_head_after got %h want %h", sample_data, head); end
    tick(2);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky_hold got %b want 1", overrun); end
    pulse_clear();
    checks += 2;
    if (overrun !== 1'b0)     begin errors++; $display("FAIL ovr_clear_overrun got %b want 0", overrun); end
    if (missed_cnt !== 16'h0) begin errors++; $display("FAIL ovr_clear_missed got %0d want 0", missed_cnt); end
    sample_ready = 1'b1;
    tick(8);
    checks++;
    if (got_samp.size() - got_idx != 4) begin
      errors++;
      $display("FAIL ovr_sample_count got %0d want 4", got_samp.size() - got_idx);
    end
    for (int i = 0; got_idx + i < got_samp.size() && exp_idx + i < exp_samp.size(); i++) begin
      checks++;
      if (got_samp[got_idx+i] !== exp_samp[exp_idx+i]) begin
        errors++;
        $display("FAIL ovr_sample[%0d] got %h want %h", i, got_samp[got_idx+i], exp_samp[exp_idx+i]);
      end
    end
    got_idx = got_samp.size();
    exp_idx = exp_samp.size();
  endtask

  task automatic test_reset_mid_op();
    sample_ready = 1'b0;
    rate_div = 16'd0;
    phase_inc = 16'd40000;
    ph_base = ph_log.size();
    enable = 1'b1;
    tick(1);
    tick(6);
    checks += 5;
    if (missed_cnt !== 16'd1)  begin errors++; $display("FAIL rmo_missed_before got %0d want 1", missed_cnt); end
    if (sample_valid !== 1'b1) begin errors++; $display("FAIL rmo_valid_before got %b want 1", sample_valid); end
    if (ph_log.size() - ph_base != 4) begin
      errors++;
      $display("FAIL rmo_pulse_count got %0d want 4", ph_log.size() - ph_base);
    end else begin
      if (ph_log[ph_base+1] !== 16'd25736) begin errors++; $display("FAIL rmo_clamp_step got %0d want 25736", ph_log[ph_base+1]); end
      if (ph_log[ph_base+2] !== 16'd0)     begin errors++; $display("FAIL rmo_clamp_wrap got %0d want 0", ph_log[ph_base+2]); end
    end
    #2;
    rst = 1'b1;
    enable = 1'b0;
    #1;
    checks += 7;
    if (busy !== 1'b0)          begin errors++; $display("FAIL rmo_busy got %b want 0", busy); end
    if (phase_tvalid !== 1'b0)  begin errors++; $display("FAIL rmo_phase_tvalid got %b want 0", phase_tvalid); end
    if (phase_tdata !== 16'h0)  begin errors++; $display("FAIL rmo_phase_tdata got %h want 0000", phase_tdata); end
    if (sample_valid !== 1'b0)  begin errors++; $display("FAIL rmo_sample_valid got %b want 0", sample_valid); end
    if (sample_data !== 16'h0)  begin errors++; $display("FAIL rmo_sample_data got %h want 0000", sample_data); end
    if (overrun !== 1'b0)       begin errors++; $display("FAIL rmo_overrun got %b want 0", overrun); end
    if (missed_cnt !== 16'h0)   begin errors++; $display("FAIL rmo_missed got %h want 0000", missed_cnt); end
    rst = 1'b0;
    got_idx = got_samp.size();
    exp_idx = exp_samp.size();
    sample_ready = 1'b1;
    tick(8);
    checks += 2;
    if (got_samp.size() - got_idx != 2) begin
      errors++;
      $display("FAIL rmo_inflight_count got %0d want 2", got_samp.size() - got_idx);
    end
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL rmo_drained got %b want 0", sample_valid); end
    for (int i = 0; got_idx + i < got_samp.size() && exp_idx + i < exp_samp.size(); i++) begin
      checks++;
      if (got_samp[got_idx+i] !== exp_samp[exp_idx+i]) begin
        errors++;
        $display("FAIL rmo_sample[%0d] got %h want %h", i, got_samp[got_idx+i], exp_samp[exp_idx+i]);
      end
    end
    got_idx = got_samp.size();
    exp_idx = exp_samp.size();
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_rate_divider();
    test_backpressure();
    test_stop_mid_run();
    test_overrun();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
